// File: rtl/unsigned_adder_carry_serial.sv
// ---------------------------------------------------------------------------
// unsigned_adder_carry_serial
//
// Bit-serial unsigned adder with carry-in and carry-out. It computes
// {co, res} = a + b + ci one bit per clock, LSB first, so the datapath costs a
// single full adder plus shift registers instead of a WIDTH-bit carry chain.
// It is the additive counterpart of the serial subtractor-with-borrow.
//
// Parameters:
//   WIDTH  operand/result width in bits (must be >= 2)
//   CNT_W  bit-counter width (2**CNT_W must exceed WIDTH)
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous reset, active-low; aborts any operation in flight
//   start  in   request, accepted in IDLE or FIN
//   a, b   in   operands, sampled only when start is accepted
//   ci     in   carry-in, sampled only when start is accepted
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse; res/co are valid from this cycle
//   res    out  registered sum modulo 2**WIDTH, holds until the next completion
//   co     out  registered carry-out (bit WIDTH of a + b + ci)
// ---------------------------------------------------------------------------
module unsigned_adder_carry_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             co
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] s_next;

  // One full adder on the current LSBs. s_next is the sum shift register as
  // it will look after this bit, which lets the final edge copy the complete
  // sum straight into res without an extra cycle.
  always_comb begin
    sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    s_next     = {sum_bit, s_sh[WIDTH-1:1]};
  end

  // Control FSM and datapath share one block so busy/done/res/co are all
  // registered. FIN accepts a new start so operations can run back-to-back,
  // while a start seen during RUN is simply not looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      co    <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ci;
            s_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_next;
          s_sh  <= s_next;
          cnt   <= cnt + CNT_W'(1);
          // The last bit is consumed on this edge; publish the result now.
          if (cnt == LAST_BIT) begin
            res   <= s_next;
            co    <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_adder_carry_serial.sv
// ---------------------------------------------------------------------------
// tb_unsigned_adder_carry_serial
//
// Self-checking bench for the bit-serial adder. A behavioural model tracks
// each accepted request as "sum = a + b + ci, due WIDTH edges later" and a
// compare process checks busy/done/res/co against it on every falling edge.
// Directed scenarios add literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_unsigned_adder_carry_serial;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ci = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             co;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  unsigned_adder_carry_serial #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .ci   (ci),
    .busy (busy),
    .done (done),
    .res  (res),
    .co   (co)
  );

  always #5 clk = ~clk;

  // Shared comparison helper; every check in the bench goes through here.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request is remembered as a plain integer
  // sum together with how many edges remain until it is due.
  int              m_left = 0;
  logic [WIDTH:0]  m_pend = '0;
  logic [WIDTH:0]  m_result = '0;
  bit              m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      m_pend   = '0;
      m_result = '0;
      m_done   = 1'b0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_pend = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        m_left = WIDTH;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done   = 1'b1;
        m_result = m_pend;
      end
    end
  end

  // Every falling edge, the DUT outputs must agree with the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("cyc_busy", 32'(busy), 32'(m_left > 0));
      check_output("cyc_done", 32'(done), 32'(m_done));
      check_output("cyc_res", 32'(res), 32'(m_result[WIDTH-1:0]));
      check_output("cyc_co", 32'(co), 32'(m_result[WIDTH]));
      if (busy && done) check_output("busy_and_done", 32'd1, 32'd0);
    end
  end

  // Wait for done, bounded; returns the number of falling edges waited.
  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 25);
    if (!done) check_output({name, "_timeout"}, 32'(n), 32'd9);
  endtask

  // Issue one request, scramble the inputs afterwards, and check the
  // latency and {co,res} against plain arithmetic.
  task automatic apply_stimulus(input string name, input logic [WIDTH-1:0] ta,
                                input logic [WIDTH-1:0] tb, input logic tci,
                                input logic [WIDTH:0] exp);
    int n;
    @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
    n = 1;
    while (!done && n < 25) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_latency"}, 32'(n), 32'(WIDTH + 1));
    check_output({name, "_res"}, 32'(res), 32'(exp[WIDTH-1:0]));
    check_output({name, "_co"}, 32'(co), 32'(exp[WIDTH]));
  endtask

  initial begin
    int n;
    int done_cnt;
    logic [WIDTH-1:0] ra, rb;
    logic             rci;

    // Reset asserted mid-cycle: outputs must clear without any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_res", 32'(res), 32'h00);
    check_output("rst_co", 32'(co), 32'd0);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_res", 32'(res), 32'h00);

    // Basic add and carry-boundary cases with hand-computed expectations.
    apply_stimulus("basic", 8'h12, 8'h34, 1'b0, 9'h046);
    apply_stimulus("ff_00_1", 8'hFF, 8'h00, 1'b1, 9'h100);
    apply_stimulus("c8_64_1", 8'hC8, 8'h64, 1'b1, 9'h12D);
    apply_stimulus("ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Back-to-back with start held high; res must hold 0x30 until the
    // second completion.
    @(negedge clk);
    a = 8'h10; b = 8'h20; ci = 1'b0; start = 1'b1;
    wait_done("b2b1", n);
    check_output("b2b1_latency", 32'(n), 32'd9);
    check_output("b2b1_res", 32'(res), 32'h30);
    check_output("b2b1_co", 32'(co), 32'd0);
    a = 8'h80; b = 8'h80;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) check_output("b2b_hold_res", 32'(res), 32'h30);
    end while (!done && n < 25);
    start = 1'b0;
    check_output("b2b2_spacing", 32'(n), 32'd9);
    check_output("b2b2_res", 32'(res), 32'h00);
    check_output("b2b2_co", 32'(co), 32'd1);
    repeat (3) @(negedge clk);

    // A start raised while busy must be ignored entirely.
    @(negedge clk);
    a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", n);
    check_output("busy_start_res", 32'(res), 32'h02);
    check_output("busy_start_co", 32'(co), 32'd0);
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output("busy_start_extra_done", 32'(done_cnt), 32'd0);

    // Reset in the middle of an operation aborts it with no late done.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_res", 32'(res), 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output("abort_no_done", 32'(done_cnt), 32'd0);
    apply_stimulus("after_abort", 8'h7F, 8'h01, 1'b0, 9'h080);

    // Randomized single operations checked against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rci = 1'($urandom);
      apply_stimulus("rand_op", ra, rb, rci,
                     {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rci});
    end

    // Free-running random start/operand traffic; only the model checks this.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      ci = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unsigned_adder_carry_serial.md
Name: unsigned_adder_carry_serial

Overview:
- Bit-serial unsigned adder with carry-in and carry-out. It is the additive counterpart of the datapath's unsigned subtractor-with-borrow.
- Computes RES = A + B + CI over WIDTH clock cycles, one bit per cycle, LSB first.
- Uses a START/BUSY/DONE handshake.
- Used where area matters more than latency, such as the accumulator paths next to the subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous reset, active-low.
- START  input  1  request; sampled on CLK rising edge.
- A  input  WIDTH  augend; sampled only when START is accepted.
- B  input  WIDTH  addend; sampled only when START is accepted.
- CI  input  1  carry-in; sampled only when START is accepted.
- BUSY  output  1  high while an addition is in progress.
- DONE  output  1  one-cycle pulse; RES/CO are valid from this cycle.
- RES  output  WIDTH  registered sum, modulo 2**WIDTH.
- CO  output  1  registered carry-out (bit WIDTH of A+B+CI).

Behaviour:
- Reset:
  - Clock is CLK; reset is RST_N, asynchronous, active-low.
  - On reset: state=IDLE, BUSY=0, DONE=0, RES=0, CO=0, internal shift registers, carry and counter = 0.
  - Reset mid-operation aborts the addition immediately.
  - After release, the block is in IDLE and no DONE is produced for the aborted operation.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 → load A_sh=A, B_sh=B, c=CI, cnt=0, S_sh=0; go to RUN.
  - BUSY=1 from the next cycle.
- RUN, each edge:
  - s = A_sh[0]^B_sh[0]^c.
  - c = majority(A_sh[0], B_sh[0], c).
  - Shift A_sh and B_sh right by one.
  - S_sh = {s, S_sh[WIDTH-1:1]}.
  - cnt += 1.
- RUN exit:
  - On the edge where cnt == WIDTH-1, the last bit is processed and the state goes to FIN.
  - On that same edge, RES <= final S_sh value and CO <= final c.
- FIN:
  - BUSY=0, DONE=1 for exactly this cycle.
  - START=1 here is accepted: operands load and the state goes to RUN, giving back-to-back operation.
  - Otherwise the state goes to IDLE.
- Latency:
  - START sampled at edge k.
  - BUSY=1 after edges k .. k+WIDTH-1.
  - DONE=1 and RES/CO valid after edge k+WIDTH.
  - Total latency is WIDTH+1 edges, i.e. 9 cycles at WIDTH=8.
- START while BUSY=1 is ignored. Operands are not re-sampled and the current operation is unaffected.
- A/B/CI changes after acceptance have no effect.
- RES/CO hold the last completed result until the next FIN. They are not cleared by START and not disturbed during RUN.
- DONE and BUSY are never high simultaneously.
- Arithmetic:
  - Pure unsigned, modulo 2**WIDTH; no saturation and no overflow flag beyond CO.
  - {CO,RES} == A + B + CI exactly, treated as a WIDTH+1-bit value.

Test Plan:
- Reset then idle: assert RST_N=0 mid-cycle → BUSY=0, DONE=0, RES=0x00, CO=0 immediately, without waiting for a clock; all hold with START=0 for 20 cycles.
- Basic add: A=0x12, B=0x34, CI=0, START pulse → BUSY high 8 cycles, DONE pulse on cycle 9, RES=0x46, CO=0.
- Carry propagation and boundary cases:
  - A=0xFF, B=0x00, CI=1 → RES=0x00, CO=1.
  - A=0xC8 (200), B=0x64 (100), CI=1 → RES=0x2D, CO=1.
  - A=0xFF, B=0xFF, CI=1 → RES=0xFF, CO=1.
- START while busy: start A=0x01, B=0x01, CI=0; at cycle 3 pulse START with A=0xAA, B=0x55 → exactly one DONE, RES=0x02, CO=0; no second DONE.
- Back-to-back: hold START=1 continuously, changing operands each DONE cycle (0x10+0x20, then 0x80+0x80) → DONE every 9 cycles; results 0x30/CO=0, then 0x00/CO=1; RES holds 0x30 until the second DONE.
- Reset mid-operation: start 0x7F+0x01, drop RST_N at cycle 4 for 2 cycles → BUSY=0, RES=0x00 immediately; no DONE afterwards; a new START yields the correct result 0x80/CO=0.
